// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the register-file write port: pipeline writebacks first, buffered long-latency returns in free slots.
// Latency: one cycle from selection to w_v_o/w_addr_o/w_data_o. A buffered return is written no earlier than the cycle after the cycle it was enqueued.
// Backpressure: primary is never stalled. Secondary uses valid/ready (ready = FIFO not full). stall_o asks upstream to free a slot.

// Circular buffer with a registered occupancy count. The caller never enqueues when full or dequeues when empty.
// Latency: the head is readable the cycle after the enqueue edge (no bypass).
// Backpressure: none internally; the caller gates enq_v_i with its own ready.
module regfile_wb_arbiter_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         enq_v_i,
  input  logic [width_p-1:0]           enq_data_i,
  input  logic                         deq_v_i,
  output logic [width_p-1:0]           deq_data_o,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;

  // Pointers wrap modulo the depth, which need not be a power of two.
  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Next-state for pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq_v_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (deq_v_i) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({enq_v_i, deq_v_i})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; an async reset discards all buffered entries.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (enq_v_i) mem_q[wr_ptr_q] <= enq_data_i;
  end

  assign deq_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// Merges primary writebacks and FIFO-buffered secondary returns onto the single register-file write port.
// Latency: selected write is registered and appears one cycle later; x0 writes are consumed without a write pulse.
// Backpressure: ret_ready_o from registered FIFO count only; stall_o registered once returns starve for starve_limit_p edges.
module regfile_wb_arbiter #(
  parameter int width_p           = 32,
  parameter int els_p             = 32,
  parameter int x0_tied_to_zero_p = 1,
  parameter int fifo_els_p        = 4,
  parameter int starve_limit_p    = 8,
  localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     int_v_i,
  input  logic [addr_width_lp-1:0] int_addr_i,
  input  logic [width_p-1:0]       int_data_i,
  input  logic                     ret_v_i,
  input  logic [addr_width_lp-1:0] ret_addr_i,
  input  logic [width_p-1:0]       ret_data_i,
  output logic                     ret_ready_o,
  output logic [els_p-1:0]         pending_o,
  output logic                     stall_o,
  output logic                     w_v_o,
  output logic [addr_width_lp-1:0] w_addr_o,
  output logic [width_p-1:0]       w_data_o
);

  localparam int  cnt_w_lp   = (fifo_els_p + 1 > 1) ? $clog2(fifo_els_p + 1) : 1;
  localparam int  st_w_lp    = (starve_limit_p + 1 > 1) ? $clog2(starve_limit_p + 1) : 1;
  localparam bit  x0_en_lp   = (x0_tied_to_zero_p != 0);

  typedef struct packed {
    logic [addr_width_lp-1:0] addr;
    logic [width_p-1:0]       data;
  } wb_entry_t;

  localparam int entry_w_lp = $bits(wb_entry_t);

  wb_entry_t              ret_entry, head_entry, sel_entry;
  logic [cnt_w_lp-1:0]    fifo_count;
  logic                   fifo_nonempty;
  logic                   enq_v, deq_v, sel_v;
  logic                   enq_hit;
  logic [els_p-1:0]       enq_mask, deq_mask;

  logic [els_p-1:0]       pending_q, pending_d;
  logic [st_w_lp-1:0]     starve_q, starve_d;
  logic                   stall_q, stall_d;
  logic                   w_v_q, w_v_d;
  logic [addr_width_lp-1:0] w_addr_q;
  logic [width_p-1:0]     w_data_q;

  assign ret_entry = '{addr: ret_addr_i, data: ret_data_i};

  regfile_wb_arbiter_fifo #(
    .width_p (entry_w_lp),
    .els_p   (fifo_els_p)
  ) ret_fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .enq_v_i    (enq_v),
    .enq_data_i (ret_entry),
    .deq_v_i    (deq_v),
    .deq_data_o (head_entry),
    .count_o    (fifo_count)
  );

  // Ready comes from the registered count only, so a full FIFO refuses even while draining.
  assign ret_ready_o   = (fifo_count != cnt_w_lp'(fifo_els_p));
  assign fifo_nonempty = (fifo_count != '0);
  assign enq_v         = ret_v_i & ret_ready_o;

  // Primary always wins the slot; the FIFO head drains only into idle cycles.
  always_comb begin
    sel_v     = int_v_i | fifo_nonempty;
    deq_v     = ~int_v_i & fifo_nonempty;
    sel_entry = int_v_i ? '{addr: int_addr_i, data: int_data_i} : head_entry;
    w_v_d     = sel_v & ~(x0_en_lp && (sel_entry.addr == '0));
  end

  // One-hot masks for the registers touched by this cycle's enqueue and dequeue.
  always_comb begin
    enq_mask = '0;
    deq_mask = '0;
    for (int r = 0; r < els_p; r++) begin
      if (enq_v && (ret_addr_i == addr_width_lp'(r)))      enq_mask[r] = 1'b1;
      if (deq_v && (head_entry.addr == addr_width_lp'(r))) deq_mask[r] = 1'b1;
    end
    enq_hit   = |(pending_q & enq_mask);
    pending_d = (pending_q & ~deq_mask) | enq_mask;
  end

  // Starvation count: grows while the primary holds the slot over a waiting return, resets on drain or empty.
  always_comb begin
    if (!fifo_nonempty || deq_v) begin
      starve_d = '0;
    end else if (int_v_i && (starve_q != st_w_lp'(starve_limit_p))) begin
      starve_d = starve_q + st_w_lp'(1);
    end else begin
      starve_d = starve_q;
    end
    stall_d = (starve_d == st_w_lp'(starve_limit_p));
  end

  // Registered state and write-port outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_q <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      w_v_q     <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
    end else begin
      pending_q <= pending_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      w_v_q     <= w_v_d;
      if (w_v_d) begin
        w_addr_q <= sel_entry.addr;
        w_data_q <= sel_entry.data;
      end
    end
  end

  assign pending_o = pending_q;
  assign stall_o   = stall_q;
  assign w_v_o     = w_v_q;
  assign w_addr_o  = w_addr_q;
  assign w_data_o  = w_data_q;

  // Upstream must honour stall_o and keep at most one buffered return per register.
  a_no_int_during_stall: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(int_v_i && stall_q));
  a_one_return_per_reg: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(enq_v && enq_hit));

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback stage directly upstream of the core register file's single write port.
- Merges two writeback sources:
  - Primary: in-order pipeline writeback. Always accepted, no backpressure.
  - Secondary: long-latency returns (remote loads, idiv). Buffered in a small FIFO and drained into free write slots.
- Tracks which registers have buffered returns in flight, for hazard checks upstream.
- Raises a registered stall request when the buffered returns are starved too long.

Parameters:
- width_p, (required), data width of a register.
- els_p, (required), number of registers.
- x0_tied_to_zero_p, (required), when 1, writes to addr 0 are consumed but never issued.
- fifo_els_p, 4, secondary FIFO depth; must be ≥2.
- starve_limit_p, 8, consecutive blocked cycles before stall_o asserts; must be ≥1.
- addr_width_lp, `BSG_SAFE_CLOG2(els_p), register address width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- int_v_i  in  1  primary writeback valid.
- int_addr_i  in  addr_width_lp  primary destination.
- int_data_i  in  width_p  primary data.
- ret_v_i  in  1  secondary return valid.
- ret_addr_i  in  addr_width_lp  secondary destination.
- ret_data_i  in  width_p  secondary data.
- ret_ready_o  out  1  secondary accept (valid/ready handshake).
- pending_o  out  els_p  bit r set while a buffered return to register r is in flight.
- stall_o  out  1  request for upstream to hold int_v_i low.
- w_v_o  out  1  register-file write enable.
- w_addr_o  out  addr_width_lp  write address.
- w_data_o  out  width_p  write data.

Behaviour:
- Reset (async, reset_n_i=0):
  - FIFO empty, starve counter 0.
  - pending_o=0, stall_o=0, w_v_o=0, w_addr_o=0, w_data_o=0.
  - ret_ready_o=1 as soon as reset deasserts.
  - Reset mid-operation discards all buffered returns; nothing is written afterward.
- Secondary enqueue:
  - Enqueue occurs on a clock edge with ret_v_i & ret_ready_o.
  - ret_ready_o = (count != fifo_els_p). It is computed from the registered count only; no same-cycle dequeue credit, so a full FIFO stays not-ready for that cycle.
- No bypass: an entry enqueued at edge N is eligible for dequeue in cycle N (after the edge) at the earliest, and is written (w_v_o=1) in cycle N+1.
- Selection each cycle:
  - If int_v_i=1, the primary is selected.
  - Otherwise, if the FIFO is non-empty, the head is dequeued.
  - Otherwise nothing is selected.
  - Primary always wins, including while stall_o=1. int_v_i=1 during stall_o is a protocol violation and must trigger a simulation assertion.
- Output register: the selected write appears on w_v_o/w_addr_o/w_data_o exactly one cycle later.
- x0 handling: if x0_tied_to_zero_p=1 and the selected addr is 0, w_v_o=0 that cycle. A FIFO entry is still dequeued and its pending bit cleared.
- pending_o:
  - Bit set at the enqueue edge; cleared at the dequeue edge.
  - Upstream guarantees at most one outstanding return per register. Enqueue to an address whose bit is already set is a protocol violation (assertion).
  - Simultaneous enqueue of addr A and dequeue of a different addr B updates both bits.
- Starve counter:
  - Increments at each edge where the FIFO is non-empty and int_v_i=1, saturating at starve_limit_p.
  - Clears at any dequeue edge, or whenever the FIFO is empty.
- stall_o = (counter == starve_limit_p). It is driven purely from a register and is clean for upstream timing.
- Pointer wrap: read/write pointers wrap modulo fifo_els_p; count width `BSG_SAFE_CLOG2(fifo_els_p+1).
- Full and dequeue in the same cycle: the dequeue happens; the enqueue is refused (ret_ready_o was 0).

Test Plan:
- Primary only: int_v_i=1, addr 5, data 0xDEADBEEF at cycle 3 -> w_v_o=1, w_addr_o=5, w_data_o=0xDEADBEEF in cycle 4; ret_ready_o stays 1.
- Secondary only: ret_v_i at cycle 2, addr 7, data 0x1234 -> pending_o[7]=1 in cycle 3; write of addr 7 / 0x1234 appears in cycle 4; pending_o[7]=0 in cycle 4.
- Fill/backpressure (fifo_els_p=4):
  - int_v_i held 1 while 5 returns are offered to addrs 1..5 -> ret_ready_o=0 after the 4th accept; addr 5 is held by its source.
  - Releasing int_v_i -> writes drain in order 1, 2, 3, 4, then 5, one per cycle.
- Starvation (starve_limit_p=4):
  - One return is buffered and int_v_i=1 continuously -> stall_o=1 in the 4th cycle after the entry becomes eligible.
  - Upstream drops int_v_i -> return written next cycle; stall_o=0 the cycle after the dequeue.
- x0 drop: x0_tied_to_zero_p=1, return to addr 0 -> no w_v_o pulse; FIFO count decrements; pending_o[0] clears. Same for a primary write to addr 0.
- Async reset: assert reset_n_i mid-cycle with 3 entries buffered -> outputs zero immediately; after release, no writes occur and ret_ready_o=1.
